// File: rtl/gpio_pkg.sv
// GPIO input conditioning: shared defaults and the
// per-bit debounce filter state.
package gpio_pkg;

  localparam int unsigned GPIO_SYNC_STAGES_DEF = 2;
  localparam int unsigned GPIO_DB_W_DEF        = 4;

  typedef struct packed {
    logic [GPIO_DB_W_DEF-1:0] cnt;
    logic                     level;
  } gpio_filt_t;

endpackage

// File: rtl/gpio_sync_bit.sv
// Single-bit multi-flop synchroniser for an asynchronous
// pin level, asynchronously reset to 0.
module gpio_sync_bit
  import gpio_pkg::*;
#(
  parameter int unsigned STAGES = GPIO_SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/gpio_in_filter.sv
// GPIO input stage: synchronise, optionally debounce on a
// shared prescaled tick, and emit registered edge pulses.
module gpio_in_filter
  import gpio_pkg::*;
#(
  parameter int unsigned NUM_BITS    = 32,
  parameter int unsigned SYNC_STAGES = GPIO_SYNC_STAGES_DEF,
  parameter int unsigned PRESCALE_W  = 16,
  parameter int unsigned DB_W        = GPIO_DB_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_BITS-1:0]   gpio_raw_i,
  input  logic [NUM_BITS-1:0]   filt_en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [DB_W-1:0]       debounce_len,
  output logic [NUM_BITS-1:0]   gpio_o,
  output logic [NUM_BITS-1:0]   rise_o,
  output logic [NUM_BITS-1:0]   fall_o,
  output logic                  tick_o
);

  logic [NUM_BITS-1:0] sync_s;

  for (genvar g = 0; g < NUM_BITS; g++) begin : g_sync
    gpio_sync_bit #(
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     (gpio_raw_i[g]),
      .q_o     (sync_s[g])
    );
  end

  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic                  tick_q, tick_d;

  // >= so a prescale lowered below pcnt still ticks promptly
  always_comb begin
    tick_d = (pcnt_q >= prescale);
    pcnt_d = tick_d ? '0 : pcnt_q + 1'b1;
  end

  gpio_filt_t [NUM_BITS-1:0] st_q, st_d;
  logic [NUM_BITS-1:0]       lvl_q, lvl_d;
  logic [NUM_BITS-1:0]       rise_q, fall_q;

  always_comb begin
    st_d  = st_q;
    lvl_q = '0;
    lvl_d = '0;
    for (int i = 0; i < NUM_BITS; i++) begin
      if (!filt_en[i]) begin
        st_d[i].level = sync_s[i];
        st_d[i].cnt   = '0;
      end else if (sync_s[i] == st_q[i].level) begin
        st_d[i].cnt = '0;
      end else if (tick_q) begin
        if (st_q[i].cnt >= debounce_len) begin
          st_d[i].level = sync_s[i];
          st_d[i].cnt   = '0;
        end else begin
          st_d[i].cnt = st_q[i].cnt + 1'b1;
        end
      end
      lvl_q[i] = st_q[i].level;
      lvl_d[i] = st_d[i].level;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
      st_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= tick_d;
      st_q   <= st_d;
      rise_q <= lvl_d & ~lvl_q;
      fall_q <= ~lvl_d & lvl_q;
    end
  end

  assign gpio_o = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign tick_o = tick_q;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed bench for gpio_in_filter: table vectors plus
// hand sequences for prescaler, glitch and reset cases.
module tb_gpio_in_filter;

  logic        clk;
  logic        reset_n;
  logic [31:0] gpio_raw_i;
  logic [31:0] filt_en;
  logic [15:0] prescale;
  logic [3:0]  debounce_len;
  logic [31:0] gpio_o;
  logic [31:0] rise_o;
  logic [31:0] fall_o;
  logic        tick_o;

  int ntests;
  int nfail;

  gpio_in_filter #(
    .NUM_BITS    (32),
    .SYNC_STAGES (2),
    .PRESCALE_W  (16),
    .DB_W        (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .gpio_raw_i   (gpio_raw_i),
    .filt_en      (filt_en),
    .prescale     (prescale),
    .debounce_len (debounce_len),
    .gpio_o       (gpio_o),
    .rise_o       (rise_o),
    .fall_o       (fall_o),
    .tick_o       (tick_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] raw;
    logic [31:0] filt;
    logic [15:0] pre;
    logic [3:0]  len;
    int          wait_n;
    logic [31:0] eg;
    logic [31:0] er;
    logic [31:0] ef;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // step past the next rising edge; outputs are settled here
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [31:0] raw,
                          input logic [31:0] filt,
                          input logic [15:0] pre,
                          input logic [3:0]  len);
    reset_n      = 1'b0;
    gpio_raw_i   = raw;
    filt_en      = filt;
    prescale     = pre;
    debounce_len = len;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    ntests = 0;
    nfail  = 0;
    do_reset(32'h0, 32'h0, 16'd0, 4'd0);
    chk("rst_gpio", gpio_o, 32'h0);
    chk("rst_rise", rise_o, 32'h0);
    chk("rst_fall", fall_o, 32'h0);
    chk("rst_tick", {31'h0, tick_o}, 32'h0);

    // unfiltered bit 3, then debounced bit 0 with L=3
    vt.push_back('{32'h0, 32'h0, 16'd0, 4'd0, 3, 32'h0, 32'h0, 32'h0});
    vt.push_back('{32'h8, 32'h0, 16'd0, 4'd0, 2, 32'h0, 32'h0, 32'h0});
    vt.push_back('{32'h8, 32'h0, 16'd0, 4'd0, 1, 32'h8, 32'h8, 32'h0});
    vt.push_back('{32'h8, 32'h0, 16'd0, 4'd0, 1, 32'h8, 32'h0, 32'h0});
    vt.push_back('{32'h0, 32'h0, 16'd0, 4'd0, 3, 32'h0, 32'h0, 32'h8});
    vt.push_back('{32'h0, 32'h0, 16'd0, 4'd0, 1, 32'h0, 32'h0, 32'h0});
    vt.push_back('{32'h0, 32'h1, 16'd0, 4'd3, 2, 32'h0, 32'h0, 32'h0});
    vt.push_back('{32'h1, 32'h1, 16'd0, 4'd3, 5, 32'h0, 32'h0, 32'h0});
    vt.push_back('{32'h1, 32'h1, 16'd0, 4'd3, 1, 32'h1, 32'h1, 32'h0});
    vt.push_back('{32'h1, 32'h1, 16'd0, 4'd3, 1, 32'h1, 32'h0, 32'h0});
    vt.push_back('{32'h0, 32'h1, 16'd0, 4'd3, 5, 32'h1, 32'h0, 32'h0});
    vt.push_back('{32'h0, 32'h1, 16'd0, 4'd3, 1, 32'h0, 32'h0, 32'h1});
    vt.push_back('{32'h0, 32'h1, 16'd0, 4'd3, 1, 32'h0, 32'h0, 32'h0});

    for (int v = 0; v < vt.size(); v++) begin
      gpio_raw_i   = vt[v].raw;
      filt_en      = vt[v].filt;
      prescale     = vt[v].pre;
      debounce_len = vt[v].len;
      repeat (vt[v].wait_n) cyc();
      chk($sformatf("vec%0d_gpio", v), gpio_o, vt[v].eg);
      chk($sformatf("vec%0d_rise", v), rise_o, vt[v].er);
      chk($sformatf("vec%0d_fall", v), fall_o, vt[v].ef);
    end

    // 3-cycle glitch on bit 0 is discarded, then a held level is taken
    gpio_raw_i = 32'h1;
    for (int k = 1; k <= 13; k++) begin
      cyc();
      if (k == 3) gpio_raw_i = 32'h0;
      chk($sformatf("glitch%0d_gpio", k), gpio_o, 32'h0);
      chk($sformatf("glitch%0d_edge", k), rise_o | fall_o, 32'h0);
    end
    gpio_raw_i = 32'h1;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      chk($sformatf("hold%0d_gpio", k), gpio_o,
          (k >= 6) ? 32'h1 : 32'h0);
      chk($sformatf("hold%0d_rise", k), rise_o,
          (k == 6) ? 32'h1 : 32'h0);
    end

    // prescale=4: tick every 5 cycles, bit 5 taken on 2nd tick
    do_reset(32'h0, 32'h20, 16'd4, 4'd1);
    for (int k = 1; k <= 17; k++) begin
      cyc();
      chk($sformatf("pre4_%0d_tick", k), {31'h0, tick_o},
          (k % 5 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("pre4_%0d_gpio", k), gpio_o,
          (k >= 16) ? 32'h20 : 32'h0);
      chk($sformatf("pre4_%0d_rise", k), rise_o,
          (k == 16) ? 32'h20 : 32'h0);
      if (k == 5) gpio_raw_i = 32'h20;
    end

    // prescale 9 -> 2 while pcnt=6 ticks on the next cycle
    do_reset(32'h0, 32'h0, 16'd9, 4'd0);
    for (int k = 1; k <= 13; k++) begin
      cyc();
      chk($sformatf("lower%0d_tick", k), {31'h0, tick_o},
          (k == 7 || k == 10 || k == 13) ? 32'h1 : 32'h0);
      if (k == 6) prescale = 16'd2;
    end

    // filt_en dropped while counting releases the pending change
    do_reset(32'h0, 32'h4, 16'd0, 4'd3);
    repeat (3) cyc();
    gpio_raw_i = 32'h4;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk($sformatf("drop%0d_gpio", k), gpio_o,
          (k >= 5) ? 32'h4 : 32'h0);
      chk($sformatf("drop%0d_rise", k), rise_o,
          (k == 5) ? 32'h4 : 32'h0);
      if (k == 4) filt_en = 32'h0;
    end

    // asynchronous reset in the middle of a debounce count
    do_reset(32'h2, 32'h1, 16'd0, 4'd3);
    repeat (5) cyc();
    chk("mid_pre_gpio", gpio_o, 32'h2);
    gpio_raw_i = 32'h3;
    repeat (4) cyc();
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_gpio", gpio_o, 32'h0);
    chk("mid_rst_rise", rise_o, 32'h0);
    chk("mid_rst_fall", fall_o, 32'h0);
    chk("mid_rst_tick", {31'h0, tick_o}, 32'h0);
    gpio_raw_i = 32'h0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk($sformatf("post%0d_gpio", k), gpio_o, 32'h0);
      chk($sformatf("post%0d_edge", k), rise_o | fall_o, 32'h0);
    end

    // all bits at once, lower half filtered with L=2
    do_reset(32'h0, 32'h0000_FFFF, 16'd0, 4'd2);
    repeat (3) cyc();
    gpio_raw_i = 32'hFFFF_FFFF;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      chk($sformatf("all%0d_gpio", k), gpio_o,
          (k >= 5) ? 32'hFFFF_FFFF :
          (k >= 3) ? 32'hFFFF_0000 : 32'h0);
      chk($sformatf("all%0d_rise", k), rise_o,
          (k == 3) ? 32'hFFFF_0000 :
          (k == 5) ? 32'h0000_FFFF : 32'h0);
      chk($sformatf("all%0d_fall", k), fall_o, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
